fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the 5-stage pipeline.
- Forwarding selects are computed one stage early, from the IF/ID source registers against the ID/EX and EX/MEM destinations. They are registered on CLOCK, so they are valid for the instruction entering EX.
- Contains a load-use stall state machine with programmable stall length.
- Supports NUM_SRC operand channels and qualifies every match with RegWrite and a non-zero destination.

---
 rtl/fwd_hazard_unit.sv | 78 +++++++
 tb/tb_fwd_hazard_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: registered operand-forwarding selects and load-use stall sequencer.
// Define HAZARD_STATS_EN to add a saturating load-use hazard counter on Hazard_Count.
module fwd_hazard_unit #(
   parameter int NUM_SRC      = 2,
   parameter int AW           = 5,
   parameter int STALL_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic                   CLOCK,
   input  logic                   RESET_N,
   input  logic [NUM_SRC*AW-1:0]  IFID_Src,
   input  logic [NUM_SRC-1:0]     IFID_SrcValid,
   input  logic [AW-1:0]          IDEX_RegD,
   input  logic                   IDEX_RegWrite,
   input  logic                   IDEX_MemRead,
   input  logic [AW-1:0]          EXMEM_RegD,
   input  logic                   EXMEM_RegWrite,
   output logic [2*NUM_SRC-1:0]   Forward_Sel,
   output logic                   Stall,
   output logic                   Flush_IDEX,
   output logic [CNT_W-1:0]       Hazard_Count
);
   localparam int SCW = $clog2(STALL_CYCLES + 1);
   typedef enum logic [0:0] {IDLE, HOLD} state_t;
   state_t state, state_nxt;
   logic [SCW-1:0] cnt, cnt_nxt;
   logic [2*NUM_SRC-1:0] sel_nxt;
   logic [NUM_SRC-1:0] hit;
   logic hazard;
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
      logic [AW-1:0] src;
      logic match_e, match_m;
      assign src = IFID_Src[i*AW +: AW];
      assign match_e = IDEX_RegWrite && IDEX_RegD != '0 && IDEX_RegD == src;
      assign match_m = EXMEM_RegWrite && EXMEM_RegD != '0 && EXMEM_RegD == src;
      assign sel_nxt[2*i +: 2] = match_e ? 2'b01 : match_m ? 2'b10 : 2'b00;
      assign hit[i] = IFID_SrcValid[i] && IDEX_RegD == src;
   end
   assign hazard = IDEX_MemRead && IDEX_RegWrite && IDEX_RegD != '0 && |hit;
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      Stall = 1'b0;
      if (state == IDLE) begin
         Stall = hazard;
         if (hazard && STALL_CYCLES > 1) begin
            state_nxt = HOLD;
            cnt_nxt = SCW'(STALL_CYCLES - 1);
         end
      end else begin
         Stall = 1'b1;
         cnt_nxt = cnt - SCW'(1);
         if (cnt == SCW'(1)) state_nxt = IDLE;
      end
      // Stall must read 0 while reset is held, even if the hazard inputs are still live
      Stall = Stall && RESET_N;
   end
   assign Flush_IDEX = Stall;
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
         cnt <= '0;
         Forward_Sel <= '0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         Forward_Sel <= Stall ? '0 : sel_nxt;
      end
   end
`ifdef HAZARD_STATS_EN
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) Hazard_Count <= '0;
      else if (state == IDLE && hazard && Hazard_Count != '1) Hazard_Count <= Hazard_Count + CNT_W'(1);
   end
`else
   assign Hazard_Count = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors against two instances (1-cycle and 3-cycle stall).
// Expected values are queued by the driver and compared by a negedge monitor.
module tb_fwd_hazard_unit;
   typedef struct packed {
      logic       rn;
      logic [9:0] src;
      logic [1:0] v;
      logic [4:0] ed;
      logic       ew;
      logic       em;
      logic [4:0] md;
      logic       mw;
   } in_t;
   typedef struct {
      int         d;
      int         n;
      logic [3:0] f;
      logic       s;
      logic [1:0] c;
   } exp_t;
   logic CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;
   in_t in1 = '0, in3 = '0;
   logic [3:0] fs1, fs3;
   logic st1, st3, fl1, fl3;
   logic [1:0] hc1, hc3;
   exp_t q[$];
   int rowno = 0, total = 0, passed = 0;
   fwd_hazard_unit #(.NUM_SRC(2), .AW(5), .STALL_CYCLES(1), .CNT_W(2)) dut1 (
      .CLOCK(CLOCK), .RESET_N(in1.rn), .IFID_Src(in1.src), .IFID_SrcValid(in1.v),
      .IDEX_RegD(in1.ed), .IDEX_RegWrite(in1.ew), .IDEX_MemRead(in1.em),
      .EXMEM_RegD(in1.md), .EXMEM_RegWrite(in1.mw),
      .Forward_Sel(fs1), .Stall(st1), .Flush_IDEX(fl1), .Hazard_Count(hc1));
   fwd_hazard_unit #(.NUM_SRC(2), .AW(5), .STALL_CYCLES(3), .CNT_W(2)) dut3 (
      .CLOCK(CLOCK), .RESET_N(in3.rn), .IFID_Src(in3.src), .IFID_SrcValid(in3.v),
      .IDEX_RegD(in3.ed), .IDEX_RegWrite(in3.ew), .IDEX_MemRead(in3.em),
      .EXMEM_RegD(in3.md), .EXMEM_RegWrite(in3.mw),
      .Forward_Sel(fs3), .Stall(st3), .Flush_IDEX(fl3), .Hazard_Count(hc3));
   function automatic in_t mk(input logic rn, input logic [4:0] s1, input logic [4:0] s0,
                              input logic [1:0] v, input logic [4:0] ed, input logic ew,
                              input logic em, input logic [4:0] md, input logic mw);
      return '{rn, {s1, s0}, v, ed, ew, em, md, mw};
   endfunction
   function automatic logic [1:0] exp_cnt(input logic [1:0] c);
`ifdef HAZARD_STATS_EN
      return c;
`else
      return 2'd0 & c;
`endif
   endfunction
   task automatic row(input int d, input in_t x, input logic [3:0] f, input logic s, input logic [1:0] c);
      @(posedge CLOCK);
      #1;
      if (d == 1) in1 = x;
      else in3 = x;
      q.push_back('{d, rowno, f, s, exp_cnt(c)});
      rowno++;
   endtask
   task automatic chk(input string nm, input int d, input int n, input int a, input int b);
      total++;
      if (a == b) passed++;
      else $display("FAIL dut%0d.%s row %0d: got %0d expected %0d", d, nm, n, a, b);
   endtask
   always @(negedge CLOCK) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("Forward_Sel", e.d, e.n, e.d == 1 ? fs1 : fs3, e.f);
         chk("Stall", e.d, e.n, e.d == 1 ? st1 : st3, e.s);
         chk("Flush_IDEX", e.d, e.n, e.d == 1 ? fl1 : fl3, e.s);
         chk("Hazard_Count", e.d, e.n, e.d == 1 ? hc1 : hc3, e.c);
      end
   end
   initial begin
      in_t hz1, hz3, z;
      hz1 = mk(1, 9, 0, 2'b10, 9, 1, 1, 0, 0);
      hz3 = mk(1, 0, 9, 2'b01, 9, 1, 1, 0, 0);
      z   = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      row(1, mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0), 4'b0000, 0, 0);
      row(1, mk(1, 5, 5, 2'b00, 5, 1, 0, 5, 1), 4'b0000, 0, 0);
      row(1, mk(1, 5, 5, 2'b00, 5, 0, 0, 5, 1), 4'b0101, 0, 0);
      row(1, mk(1, 0, 0, 2'b00, 0, 1, 0, 0, 1), 4'b1010, 0, 0);
      row(1, mk(1, 7, 7, 2'b00, 7, 0, 0, 0, 0), 4'b0000, 0, 0);
      row(1, hz1, 4'b0000, 1, 0);
      row(1, mk(1, 9, 0, 2'b10, 0, 0, 0, 9, 1), 4'b0000, 0, 1);
      row(1, mk(1, 9, 0, 2'b01, 9, 1, 1, 0, 0), 4'b1000, 0, 1);
      row(1, hz1, 4'b0100, 1, 1);
      row(1, hz1, 4'b0000, 1, 2);
      row(1, hz1, 4'b0000, 1, 3);
      row(1, hz1, 4'b0000, 1, 3);
      row(1, z, 4'b0000, 0, 3);
      row(1, mk(1, 0, 5, 2'b00, 5, 1, 0, 0, 0), 4'b0000, 0, 3);
      row(1, mk(0, 0, 5, 2'b00, 5, 1, 0, 0, 0), 4'b0000, 0, 0);
      row(1, z, 4'b0000, 0, 0);
      row(3, z, 4'b0000, 0, 0);
      row(3, hz3, 4'b0000, 1, 0);
      row(3, z, 4'b0000, 1, 1);
      row(3, mk(1, 0, 4, 2'b00, 4, 1, 0, 0, 0), 4'b0000, 1, 1);
      row(3, z, 4'b0000, 0, 1);
      row(3, mk(1, 0, 4, 2'b00, 4, 1, 0, 0, 0), 4'b0000, 0, 1);
      row(3, z, 4'b0001, 0, 1);
      row(3, hz3, 4'b0000, 1, 1);
      row(3, mk(0, 0, 9, 2'b01, 9, 1, 1, 0, 0), 4'b0000, 0, 0);
      row(3, hz3, 4'b0000, 1, 0);
      row(3, z, 4'b0000, 1, 1);
      row(3, z, 4'b0000, 1, 1);
      row(3, z, 4'b0000, 0, 1);
      @(posedge CLOCK);
      @(negedge CLOCK);
      #1;
      total++;
      if (q.size() == 0) passed++;
      else $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
